// File: rtl/i2c_regfile_target.sv
// I2C target exposing REG_COUNT 8-bit registers behind an auto-incrementing pointer; the top register is a read-only status byte.
// Optional 3-sample majority glitch filter on SCL/SDA enabled by defining I2C_GLITCH_FILTER_EN.
module i2c_regfile_target #(
    parameter logic [6:0] DEV_ADDR  = 7'h42,
    parameter int         REG_COUNT = 20
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   scl_in,
    input  logic                   sda_in,
    output logic                   sda_oe,
    input  logic [7:0]             parallel_in,
    output logic [8*REG_COUNT-1:0] registers_packed,
    output logic                   wr_strobe,
    output logic [6:0]             wr_index,
    output logic                   busy
);

    localparam logic [6:0] LAST_PTR = 7'(REG_COUNT - 1);
    localparam logic [8:0] COUNT9   = 9'(REG_COUNT);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
        S_WDATA, S_WDATA_ACK, S_RDATA, S_RACK
    } state_t;

    logic r_scl_s1, r_scl_s2, r_sda_s1, r_sda_s2;
    logic w_scl, w_sda, r_scl_q, r_sda_q;

    // Two-flop synchronizers, reset to the idle-bus level.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_scl_s1 <= 1'b1;
            r_scl_s2 <= 1'b1;
            r_sda_s1 <= 1'b1;
            r_sda_s2 <= 1'b1;
        end else begin
            r_scl_s1 <= scl_in;
            r_scl_s2 <= r_scl_s1;
            r_sda_s1 <= sda_in;
            r_sda_s2 <= r_sda_s1;
        end
    end

`ifdef I2C_GLITCH_FILTER_EN
    logic [1:0] r_scl_hist, r_sda_hist;
    logic       r_scl_flt, r_sda_flt;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Majority of the current and two previous synchronized samples; single-clock pulses never win.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_scl_hist <= 2'b11;
            r_sda_hist <= 2'b11;
            r_scl_flt  <= 1'b1;
            r_sda_flt  <= 1'b1;
        end else begin
            r_scl_hist <= {r_scl_hist[0], r_scl_s2};
            r_sda_hist <= {r_sda_hist[0], r_sda_s2};
            r_scl_flt  <= maj3(r_scl_s2, r_scl_hist[0], r_scl_hist[1]);
            r_sda_flt  <= maj3(r_sda_s2, r_sda_hist[0], r_sda_hist[1]);
        end
    end

    assign w_scl = r_scl_flt;
    assign w_sda = r_sda_flt;
`else
    assign w_scl = r_scl_s2;
    assign w_sda = r_sda_s2;
`endif

    // Previous-cycle bus levels for edge and condition detection.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_scl_q <= 1'b1;
            r_sda_q <= 1'b1;
        end else begin
            r_scl_q <= w_scl;
            r_sda_q <= w_sda;
        end
    end

    logic w_scl_rise, w_scl_fall, w_start, w_stop;
    assign w_scl_rise = w_scl & ~r_scl_q;
    assign w_scl_fall = ~w_scl & r_scl_q;
    assign w_start    = w_scl & r_scl_q & r_sda_q & ~w_sda;
    assign w_stop     = w_scl & r_scl_q & ~r_sda_q & w_sda;

    state_t     r_state, w_state_nxt;
    logic [3:0] r_cnt, w_cnt_nxt;
    logic [7:0] r_shift, w_shift_nxt;
    logic [7:0] r_tx, w_tx_nxt;
    logic [6:0] r_ptr, w_ptr_nxt;
    logic       r_rw, w_rw_nxt;
    logic       r_acked, w_acked_nxt;
    logic       r_sda_oe, w_sda_oe_nxt;
    logic       r_busy, w_busy_nxt;
    logic       w_wr_en, w_cap_status;
    logic [7:0] w_byte_in, w_rd_byte;
    logic [6:0] w_ptr_inc;
    logic [8*REG_COUNT-1:0] r_regs;
    logic       r_wr_strobe;
    logic [6:0] r_wr_index;

    assign w_byte_in = {r_shift[6:0], w_sda};
    assign w_ptr_inc = (r_ptr == LAST_PTR) ? 7'd0 : r_ptr + 7'd1;

    // Byte presented for the next read; the status slot reads the live parallel_in.
    always_comb begin
        w_rd_byte = (r_ptr == LAST_PTR) ? parallel_in : 8'h00;
        for (int i = 0; i < REG_COUNT - 1; i++) begin
            w_rd_byte = w_rd_byte | ((r_ptr == 7'(i)) ? r_regs[8*i +: 8] : 8'h00);
        end
    end

    // Protocol state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= 4'd0;
            r_shift  <= 8'h00;
            r_tx     <= 8'h00;
            r_ptr    <= 7'd0;
            r_rw     <= 1'b0;
            r_acked  <= 1'b0;
            r_sda_oe <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_shift  <= w_shift_nxt;
            r_tx     <= w_tx_nxt;
            r_ptr    <= w_ptr_nxt;
            r_rw     <= w_rw_nxt;
            r_acked  <= w_acked_nxt;
            r_sda_oe <= w_sda_oe_nxt;
            r_busy   <= w_busy_nxt;
        end
    end

    // Next-state logic: bits sampled on SCL rise, SDA drive changed only on SCL fall.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_shift_nxt  = r_shift;
        w_tx_nxt     = r_tx;
        w_ptr_nxt    = r_ptr;
        w_rw_nxt     = r_rw;
        w_acked_nxt  = r_acked;
        w_sda_oe_nxt = r_sda_oe;
        w_busy_nxt   = r_busy;
        w_wr_en      = 1'b0;
        w_cap_status = 1'b0;
        if (w_stop) begin
            w_state_nxt  = S_IDLE;
            w_sda_oe_nxt = 1'b0;
            w_busy_nxt   = 1'b0;
        end else if (w_start) begin
            w_state_nxt  = S_ADDR;
            w_cnt_nxt    = 4'd0;
            w_sda_oe_nxt = 1'b0;
        end else begin
            case (r_state)
                S_ADDR, S_PTR, S_WDATA: begin
                    if (w_scl_rise) begin
                        w_shift_nxt = w_byte_in;
                        w_cnt_nxt   = r_cnt + 4'd1;
                        if (r_state == S_WDATA && r_cnt == 4'd7) begin
                            w_wr_en   = (r_ptr != LAST_PTR);
                            w_ptr_nxt = w_ptr_inc;
                        end else begin
                            w_ptr_nxt = r_ptr;
                        end
                    end else if (w_scl_fall && r_cnt == 4'd8) begin
                        if (r_state == S_ADDR) begin
                            if (r_shift[7:1] == DEV_ADDR) begin
                                w_state_nxt  = S_ADDR_ACK;
                                w_sda_oe_nxt = 1'b1;
                                w_rw_nxt     = r_shift[0];
                                w_busy_nxt   = 1'b1;
                            end else begin
                                w_state_nxt = S_IDLE;
                                w_busy_nxt  = 1'b0;
                            end
                        end else if (r_state == S_PTR) begin
                            // Out-of-range pointer: park in IDLE so every later byte is NACKed.
                            if ({1'b0, r_shift} < COUNT9) begin
                                w_ptr_nxt    = r_shift[6:0];
                                w_sda_oe_nxt = 1'b1;
                                w_state_nxt  = S_PTR_ACK;
                            end else begin
                                w_state_nxt = S_IDLE;
                            end
                        end else begin
                            w_sda_oe_nxt = 1'b1;
                            w_state_nxt  = S_WDATA_ACK;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt;
                    end
                end
                S_ADDR_ACK, S_RACK: begin
                    if (w_scl_rise) begin
                        w_acked_nxt = ~w_sda;
                    end else if (w_scl_fall) begin
                        w_cnt_nxt = 4'd0;
                        if ((r_state == S_ADDR_ACK && r_rw) || (r_state == S_RACK && r_acked)) begin
                            w_tx_nxt     = {w_rd_byte[6:0], 1'b0};
                            w_sda_oe_nxt = ~w_rd_byte[7];
                            w_cap_status = (r_ptr == LAST_PTR);
                            w_state_nxt  = S_RDATA;
                        end else if (r_state == S_ADDR_ACK) begin
                            w_sda_oe_nxt = 1'b0;
                            w_state_nxt  = S_PTR;
                        end else begin
                            w_sda_oe_nxt = 1'b0;
                            w_state_nxt  = S_IDLE;
                        end
                    end else begin
                        w_acked_nxt = r_acked;
                    end
                end
                S_PTR_ACK, S_WDATA_ACK: begin
                    if (w_scl_fall) begin
                        w_sda_oe_nxt = 1'b0;
                        w_cnt_nxt    = 4'd0;
                        w_state_nxt  = S_WDATA;
                    end else begin
                        w_state_nxt = r_state;
                    end
                end
                S_RDATA: begin
                    if (w_scl_rise) begin
                        w_cnt_nxt = r_cnt + 4'd1;
                    end else if (w_scl_fall && r_cnt == 4'd8) begin
                        w_sda_oe_nxt = 1'b0;
                        w_ptr_nxt    = w_ptr_inc;
                        w_state_nxt  = S_RACK;
                    end else if (w_scl_fall) begin
                        w_sda_oe_nxt = ~r_tx[7];
                        w_tx_nxt     = {r_tx[6:0], 1'b0};
                    end else begin
                        w_tx_nxt = r_tx;
                    end
                end
                S_IDLE: begin
                    w_state_nxt = S_IDLE;
                end
                default: begin
                    w_state_nxt  = S_IDLE;
                    w_sda_oe_nxt = 1'b0;
                end
            endcase
        end
    end

    // Register file writes and status capture.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_regs <= '0;
        end else begin
            for (int i = 0; i < REG_COUNT - 1; i++) begin
                if (w_wr_en && (r_ptr == 7'(i))) begin
                    r_regs[8*i +: 8] <= w_byte_in;
                end
            end
            if (w_cap_status) begin
                r_regs[8*(REG_COUNT-1) +: 8] <= parallel_in;
            end
        end
    end

    // Write notification, one cycle after the last data bit is sampled.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_strobe <= 1'b0;
            r_wr_index  <= 7'd0;
        end else begin
            r_wr_strobe <= w_wr_en;
            if (w_wr_en) begin
                r_wr_index <= r_ptr;
            end
        end
    end

    assign sda_oe           = r_sda_oe;
    assign busy             = r_busy;
    assign wr_strobe        = r_wr_strobe;
    assign wr_index         = r_wr_index;
    assign registers_packed = r_regs;

endmodule

// File: tb/tb_i2c_regfile_target.sv
// Bench for i2c_regfile_target: bit-banged I2C master with a byte-level register-file model.
module tb_i2c_regfile_target;

    localparam int RC = 20;
    localparam int Q  = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic m_scl = 1'b1;
    logic m_sda = 1'b1;
    logic [7:0] parallel_in = 8'h00;
    logic sda_oe, wr_strobe, busy;
    logic [6:0] wr_index;
    logic [8*RC-1:0] registers_packed;
    wire sda_bus = m_sda & ~sda_oe;

    i2c_regfile_target #(.DEV_ADDR(7'h42), .REG_COUNT(RC)) dut (
        .clock(clock), .reset(reset), .scl_in(m_scl), .sda_in(sda_bus), .sda_oe(sda_oe),
        .parallel_in(parallel_in), .registers_packed(registers_packed),
        .wr_strobe(wr_strobe), .wr_index(wr_index), .busy(busy)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_fail = 0;
    logic [7:0] m_regs [RC];
    int m_ptr = 0;
    logic [7:0] wq [$];
    int exp_idx_q [$];
    int got_idx_q [$];

    always @(negedge clock) begin
        if (wr_strobe) got_idx_q.push_back(int'(wr_index));
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic bus_start();
        m_sda = 1'b1; tick(Q); m_scl = 1'b1; tick(Q);
        m_sda = 1'b0; tick(Q); m_scl = 1'b0; tick(Q);
    endtask

    task automatic bus_stop();
        m_sda = 1'b0; tick(Q); m_scl = 1'b1; tick(Q); m_sda = 1'b1; tick(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) begin
            m_sda = b[i]; tick(Q); m_scl = 1'b1; tick(2*Q); m_scl = 1'b0; tick(Q);
        end
        m_sda = 1'b1; tick(Q); m_scl = 1'b1; tick(Q);
        ack = ~sda_bus;
        tick(Q); m_scl = 1'b0; tick(Q);
    endtask

    task automatic recv_byte(input logic mack, output logic [7:0] b);
        m_sda = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            tick(Q); m_scl = 1'b1; tick(Q); b[i] = sda_bus; tick(Q); m_scl = 1'b0; tick(Q);
        end
        m_sda = ~mack; tick(Q); m_scl = 1'b1; tick(2*Q); m_scl = 1'b0; tick(Q);
        m_sda = 1'b1;
    endtask

    task automatic check_regs();
        for (int i = 0; i < RC - 1; i++) begin
            check($sformatf("reg%0d", i), 32'(registers_packed[8*i +: 8]), 32'(m_regs[i]));
        end
    endtask

    task automatic check_strobes();
        check("strobe_count", 32'(got_idx_q.size()), 32'(exp_idx_q.size()));
        for (int k = 0; k < exp_idx_q.size() && k < got_idx_q.size(); k++) begin
            check($sformatf("strobe_idx%0d", k), 32'(got_idx_q[k]), 32'(exp_idx_q[k]));
        end
        exp_idx_q.delete();
        got_idx_q.delete();
    endtask

    // Pointer byte followed by the bytes in wq; keep_bus leaves the bus held for a repeated START.
    task automatic write_txn(input logic [7:0] ptr, input bit keep_bus);
        logic ack;
        bit ok;
        bus_start();
        send_byte(8'h84, ack);
        check("addr_w_ack", 32'(ack), 32'd1);
        ok = (int'(ptr) < RC);
        send_byte(ptr, ack);
        check("ptr_ack", 32'(ack), 32'(ok));
        if (ok) m_ptr = int'(ptr);
        foreach (wq[k]) begin
            send_byte(wq[k], ack);
            check("wdata_ack", 32'(ack), 32'(ok));
            if (ok) begin
                if (m_ptr != RC - 1) begin
                    m_regs[m_ptr] = wq[k];
                    exp_idx_q.push_back(m_ptr);
                end
                m_ptr = (m_ptr + 1) % RC;
            end
        end
        check("busy_in_txn", 32'(busy), 32'd1);
        if (!keep_bus) begin
            bus_stop();
            tick(4);
            check("busy_after_stop", 32'(busy), 32'd0);
            check_regs();
            check_strobes();
        end
    endtask

    task automatic read_txn(input int n);
        logic ack;
        logic [7:0] got, exp;
        bus_start();
        send_byte(8'h85, ack);
        check("addr_r_ack", 32'(ack), 32'd1);
        for (int k = 0; k < n; k++) begin
            exp = (m_ptr == RC - 1) ? parallel_in : m_regs[m_ptr];
            recv_byte(k != n - 1, got);
            check($sformatf("rdata_ptr%0d", m_ptr), 32'(got), 32'(exp));
            m_ptr = (m_ptr + 1) % RC;
        end
        check("sda_released", 32'(sda_oe), 32'd0);
        check("busy_in_read", 32'(busy), 32'd1);
        bus_stop();
        tick(4);
        check("busy_after_stop", 32'(busy), 32'd0);
        check_strobes();
    endtask

    initial begin
        logic ack;
        logic [7:0] rp;
        for (int i = 0; i < RC; i++) m_regs[i] = 8'h00;

        tick(5);
        check("rst_sda_oe", 32'(sda_oe), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_wr_strobe", 32'(wr_strobe), 32'd0);
        check("rst_wr_index", 32'(wr_index), 32'd0);
        check("rst_regs", 32'(|registers_packed), 32'd0);
        reset = 1'b0;
        tick(5);

        // Two writes from pointer 3, then a bare read must start at the retained pointer 5.
        wq = '{8'hA5, 8'h5A};
        write_txn(8'h03, 1'b0);
        read_txn(1);

        // Pointer write, repeated START, read two bytes.
        wq.delete();
        write_txn(8'h02, 1'b1);
        read_txn(2);

        // Foreign address, then out-of-range pointer.
        bus_start();
        send_byte(8'h86, ack);
        check("foreign_addr_nack", 32'(ack), 32'd0);
        check("foreign_busy", 32'(busy), 32'd0);
        bus_stop();
        wq = '{8'h11};
        write_txn(8'h40, 1'b0);

        // Write across the status register and wrap to register 0, then read status.
        wq = '{8'h77, 8'h99, 8'h33};
        write_txn(8'h12, 1'b0);
        parallel_in = 8'hC3;
        wq.delete();
        write_txn(8'h13, 1'b1);
        read_txn(2);

        for (int t = 0; t < 6; t++) begin
            wq.delete();
            for (int k = 0; k < int'($urandom_range(1, 4)); k++) wq.push_back(8'($urandom));
            rp = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(RC, 255)) : 8'($urandom_range(0, RC - 1));
            write_txn(rp, 1'b0);
            parallel_in = 8'($urandom);
            wq.delete();
            write_txn(8'($urandom_range(0, RC - 1)), 1'b1);
            read_txn(int'($urandom_range(1, 4)));
        end

        // Reset in the middle of a read while the target is driving a zero bit.
        wq = '{8'h00};
        write_txn(8'h01, 1'b0);
        wq.delete();
        write_txn(8'h01, 1'b1);
        bus_start();
        send_byte(8'h85, ack);
        check("addr_r_ack_pre_rst", 32'(ack), 32'd1);
        for (int b = 0; b < 3; b++) begin
            tick(Q); m_scl = 1'b1; tick(2*Q); m_scl = 1'b0; tick(Q);
        end
        tick(Q); m_scl = 1'b1; tick(Q);
        check("drive_bit4", 32'(sda_oe), 32'd1);
        reset = 1'b1;
        #1;
        check("async_release", 32'(sda_oe), 32'd0);
        for (int i = 0; i < RC; i++) m_regs[i] = 8'h00;
        m_ptr = 0;
        tick(3);
        m_sda = 1'b1;
        tick(Q);
        reset = 1'b0;
        tick(Q);
        check("midrst_regs", 32'(|registers_packed), 32'd0);
        check("midrst_wr_index", 32'(wr_index), 32'd0);
        got_idx_q.delete();
        exp_idx_q.delete();
        parallel_in = 8'h00;
        read_txn(RC);

        // One-clock SDA low pulse with SCL high, then address bits without a real START.
        m_sda = 1'b0;
        @(posedge clock); #1;
        m_sda = 1'b1;
        tick(Q);
        m_scl = 1'b0;
        tick(Q);
        send_byte(8'h84, ack);
        check("glitch_no_ack", 32'(ack), 32'd0);
        check("glitch_busy", 32'(busy), 32'd0);
        bus_stop();
        check_strobes();
        check_regs();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_regfile_target.md
I2C_REGFILE_TARGET -- requirements
Module: i2c_regfile_target

Interface
REQ-001 Parameter DEV_ADDR, default 7'h42: 7-bit I2C target address.
REQ-002 Parameter REG_COUNT, default 20, range 2..128: number of 8-bit registers. Register REG_COUNT-1 is the read-only status register.
REQ-003 clock  input  1  sole clock, rising edge; frequency >= 16x SCL.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 scl_in  input  1  I2C SCL pin level, asynchronous.
REQ-006 sda_in  input  1  I2C SDA pin level, asynchronous.
REQ-007 sda_oe  output  1  1 = pull SDA low, 0 = release. Open-drain; the pad inverts.
REQ-008 parallel_in  input  8  status byte returned on reads of register REG_COUNT-1.
REQ-009 registers_packed  output  8*REG_COUNT  register i on bits [8i+7:8i].
REQ-010 wr_strobe  output  1  one-cycle pulse when a writable register is updated.
REQ-011 wr_index  output  7  index of the register written, valid with wr_strobe.
REQ-012 busy  output  1  high from an addressed START until STOP.

Function
REQ-013 scl_in and sda_in SHALL pass through a 2-flop synchronizer; all protocol logic SHALL use only the synchronized values.
REQ-014 START is SDA falling while SCL is high; STOP is SDA rising while SCL is high. Both SHALL be detected in any state.
REQ-015 States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK.
REQ-016 START (including repeated START) -> ADDR with the bit count cleared; STOP -> IDLE with sda_oe=0 and busy=0.
REQ-017 Data bits SHALL be sampled on the synchronized SCL rising edge. sda_oe SHALL change only on the synchronized SCL falling edge, within 1 clock of it.
REQ-018 ADDR: shift 8 bits, MSB first. If bits[7:1] match DEV_ADDR, drive ACK; bit0=0 -> PTR, bit0=1 -> RDATA. On mismatch, no ACK -> IDLE.
REQ-019 PTR: the received byte loads the pointer. If the value is < REG_COUNT, ACK. Otherwise NACK, and NACK all further bytes until STOP or START.
REQ-020 WDATA: ACK each byte and write it to register[pointer], then pointer++. After REG_COUNT-1 the pointer wraps to 0.
REQ-021 A write to register REG_COUNT-1 SHALL be ACKed, discarded, and SHALL NOT pulse wr_strobe.
REQ-022 wr_strobe SHALL pulse on the clock after the 8th data bit is sampled.
REQ-023 RDATA: shift out register[pointer] MSB first; pointer++ with wrap after the 8th bit.
REQ-024 For register REG_COUNT-1, parallel_in SHALL be captured on the SCL falling edge that begins bit 7.
REQ-025 RACK: on master ACK (SDA low) -> RDATA with the next byte. On master NACK -> release SDA and wait for STOP or START.
REQ-026 The pointer SHALL persist across transactions; a read with no preceding pointer write starts at the retained pointer.
REQ-027 Registers SHALL change only via completed write bytes; a byte interrupted by START or STOP SHALL be discarded.

Reset
REQ-028 Reset SHALL set: all registers 0x00, pointer 0, state IDLE, sda_oe 0, wr_strobe 0, wr_index 0, busy 0, synchronizers to 1 (bus idle).
REQ-029 Reset asserted mid-transfer SHALL release SDA asynchronously, with no glitch low.

Configuration
REQ-030 With macro I2C_GLITCH_FILTER_EN defined:
- a 3-sample majority filter SHALL follow each synchronizer;
- pulses of 1 clock or less SHALL be rejected;
- latency increases by 2 clocks.
Without the macro, only the 2-flop synchronizer is present and 1-clock pulses are seen.

Verification
REQ-031 Write START, 0x84, 0x03, 0xA5, 0x5A, STOP -> ACK on all four bytes; reg3=0xA5, reg4=0x5A; wr_strobe pulses with wr_index 3 then 4; pointer=5.
REQ-032 Write START, 0x84, 0x02, repeated START, 0x85, read 2 bytes (ACK, then NACK), STOP -> reads return reg2 then reg3; SDA released after the NACK.
REQ-033 Address 0x86 -> no ACK, busy stays 0, no register change. Pointer 0x40 (REG_COUNT=20) -> NACK, and the following data byte 0x11 is also NACKed.
REQ-034 Pointer 0x12, write 0x77, 0x99, 0x33 -> reg18=0x77; reg19 unchanged; wrap writes reg0=0x33. With parallel_in=0xC3, a read of reg19 returns 0xC3.
REQ-035 Reset pulsed during the 4th data bit, with sda_oe=1 -> sda_oe=0 in the same cycle; all registers read back 0x00 after a new START.
REQ-036 With I2C_GLITCH_FILTER_EN, a 1-clock SDA low pulse while SCL is high -> no START detected, state stays IDLE. Without the macro -> START detected.
